// File: rtl/obi_memory_slv_responder_if.sv
// OBI memory bus bundle between a requester (core or agent) and a memory slave.
// The A channel carries the request; the R channel carries the in-order response.
interface obi_memory_slv_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
) ();

  // A channel
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [ID_WIDTH-1:0]     aid;

  // R channel
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;
  logic [ID_WIDTH-1:0]     rid;

  modport master (
    output req, addr, we, be, wdata, aid, rready,
    input  gnt, rvalid, rdata, err, rid
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, rready,
    output gnt, rvalid, rdata, err, rid
  );

endinterface

// File: rtl/obi_memory_slv_responder.sv
// OBI memory slave responder.
// Terminates A-channel transfers against a word-addressed memory and returns
// responses in acceptance order through a small FIFO. Every entry waits a fixed
// number of cycles before it may be presented, and the head is held stable
// under rready backpressure.
module obi_memory_slv_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 1,
  parameter int MEM_DEPTH       = 1024,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_LATENCY    = 1
) (
  input logic                      clk,
  input logic                      reset,
  obi_memory_slv_responder_if.slave bus
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int OFS       = $clog2(BE_WIDTH);
  localparam int IDX_WIDTH = ADDR_WIDTH - OFS;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int CD_WIDTH  = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CD_WIDTH-1:0]  CD_START  = CD_WIDTH'(RESP_LATENCY - 1);

  // Address decode
  logic [IDX_WIDTH-1:0]  word_idx;
  logic [IDX_WIDTH-1:0]  idx_high;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  in_range;

  // Memory array; contents survive reset
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // Response FIFO storage
  logic [DATA_WIDTH-1:0] fifo_data [MAX_OUTSTANDING];
  logic                  fifo_err  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   fifo_id   [MAX_OUTSTANDING];
  logic [CD_WIDTH-1:0]   fifo_cd   [MAX_OUTSTANDING];

  // FIFO control
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;

  // Handshake qualifiers
  logic                  gnt_int;
  logic                  rvalid_int;
  logic                  accept;
  logic                  retire;
  logic                  head_ready;
  logic [DATA_WIDTH-1:0] enq_data;

  // Advance a FIFO pointer with explicit wrap so a depth of one also works
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    next_ptr = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // The sub-word offset bits are dropped; be alone chooses the lanes.
  assign word_idx = IDX_WIDTH'(bus.addr >> OFS);
  assign idx_high = word_idx >> MEM_AW;
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign in_range = (idx_high == '0);

  assign rd_word  = mem[mem_idx];
  assign enq_data = (!bus.we && in_range) ? rd_word : '0;

  // Grant only looks at the registered count, so a same-cycle retire cannot
  // open a slot until the following cycle.
  assign gnt_int    = !reset && (count < FULL_CNT);
  assign accept     = bus.req && gnt_int;

  assign head_ready = (count != '0) && (fifo_cd[rd_ptr] == '0);
  assign rvalid_int = !reset && head_ready;
  assign retire     = rvalid_int && bus.rready;

  assign bus.gnt    = gnt_int;
  assign bus.rvalid = rvalid_int;
  assign bus.rdata  = rvalid_int ? fifo_data[rd_ptr] : '0;
  assign bus.err    = rvalid_int ? fifo_err[rd_ptr]  : 1'b0;
  assign bus.rid    = rvalid_int ? fifo_id[rd_ptr]   : '0;

  // Byte-lane memory update for accepted in-range writes
  always_ff @(posedge clk) begin
    if (accept && bus.we && in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (bus.be[b]) begin
          mem[mem_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Response payload capture into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_data[wr_ptr] <= enq_data;
      fifo_err[wr_ptr]  <= !in_range;
      fifo_id[wr_ptr]   <= bus.aid;
    end
  end

  // Pointer, occupancy and per-entry latency countdown bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_cd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (fifo_cd[i] != '0) begin
          fifo_cd[i] <= fifo_cd[i] - 1'b1;
        end
      end
      if (accept) begin
        fifo_cd[wr_ptr] <= CD_START;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (retire) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_memory_slv_responder.sv
// Scoreboard bench for obi_memory_slv_responder.
// Two instances: latency 1 for the functional scenarios, latency 3 for timing.
// Stimulus pushes the hand-computed response at accept; per-DUT monitors pop
// and compare on every R handshake.
module tb_obi_memory_slv_responder;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IW   = 1;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset;

  // Free-running bench clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  obi_memory_slv_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus1 ();
  obi_memory_slv_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus2 ();

  obi_memory_slv_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_DEPTH(1024), .MAX_OUTSTANDING(MAXO), .RESP_LATENCY(1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  obi_memory_slv_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_DEPTH(1024), .MAX_OUTSTANDING(MAXO), .RESP_LATENCY(3)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic [IW-1:0] id;
  } resp_t;

  resp_t q1[$];
  resp_t q2[$];
  resp_t e1;
  resp_t e2;
  int    passed = 0;
  int    total  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
  endtask

  task automatic driveA(input int sel, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, input logic [DW-1:0] d, input logic [IW-1:0] id);
    if (sel == 1) begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.be = b; bus1.wdata = d; bus1.aid = id;
    end else begin
      bus2.req = r; bus2.we = w; bus2.addr = a; bus2.be = b; bus2.wdata = d; bus2.aid = id;
    end
  endtask

  task automatic pushExpected(input int sel, input logic [DW-1:0] d, input logic e, input logic [IW-1:0] id);
    resp_t r;
    r.data = d;
    r.err  = e;
    r.id   = id;
    if (sel == 1) q1.push_back(r);
    else          q2.push_back(r);
  endtask

  // One A-channel transfer; the expected response is queued on the accepting edge
  task automatic applyStimulus(input int sel, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b,
                               input logic [DW-1:0] d, input logic [IW-1:0] id,
                               input logic [DW-1:0] exp_data, input logic exp_err);
    int   waited;
    logic g;
    waited = 0;
    driveA(sel, 1'b1, w, a, b, d, id);
    @(negedge clk);
    g = (sel == 1) ? bus1.gnt : bus2.gnt;
    while (!g && waited < 50) begin
      waited++;
      @(negedge clk);
      g = (sel == 1) ? bus1.gnt : bus2.gnt;
    end
    if (!g) begin
      checkOutput("gnt_timeout", 64'(g), 64'd1);
      driveA(sel, 1'b0, 1'b0, '0, '0, '0, '0);
      return;
    end
    @(posedge clk);
    pushExpected(sel, exp_data, exp_err, id);
    #1;
    driveA(sel, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic waitDrain(input int sel);
    int n;
    int sz;
    n  = 0;
    sz = (sel == 1) ? q1.size() : q2.size();
    while (sz != 0 && n < 100) begin
      @(negedge clk);
      n++;
      sz = (sel == 1) ? q1.size() : q2.size();
    end
    checkOutput((sel == 1) ? "dut1_drain" : "dut2_drain", 64'(sz), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the latency-1 instance: every R handshake must match the queue head
  always @(negedge clk) begin
    if (bus1.rvalid && bus1.rready) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e1 = q1.pop_front();
        checkOutput("dut1_rdata", 64'(bus1.rdata), 64'(e1.data));
        checkOutput("dut1_err",   64'(bus1.err),   64'(e1.err));
        checkOutput("dut1_rid",   64'(bus1.rid),   64'(e1.id));
      end
    end
  end

  // Monitor for the latency-3 instance
  always @(negedge clk) begin
    if (bus2.rvalid && bus2.rready) begin
      if (q2.size() == 0) begin
        checkOutput("dut2_unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e2 = q2.pop_front();
        checkOutput("dut2_rdata", 64'(bus2.rdata), 64'(e2.data));
        checkOutput("dut2_err",   64'(bus2.err),   64'(e2.err));
        checkOutput("dut2_rid",   64'(bus2.rid),   64'(e2.id));
      end
    end
  end

  // Hang guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    reset = 1'b1;
    bus1.rready = 1'b1;
    bus2.rready = 1'b1;
    driveA(1, 1'b0, 1'b0, '0, '0, '0, '0);
    driveA(2, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("gnt_in_reset", 64'(bus1.gnt), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_rvalid", 64'(bus1.rvalid), 64'd0);
    checkOutput("rst_gnt",    64'(bus1.gnt),    64'd1);
    checkOutput("rst_rdata",  64'(bus1.rdata),  64'd0);
    checkOutput("rst_err",    64'(bus1.err),    64'd0);
    checkOutput("rst_rid",    64'(bus1.rid),    64'd0);
    checkOutput("rst_count",  64'(dut1.count),  64'd0);
    @(posedge clk);
    #1;

    // Full write then read back; write response one cycle after accept
    applyStimulus(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("wr_rsp_latency", 64'(bus1.rvalid), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Partial write immediately followed by read of the same word
    applyStimulus(1, 1'b1, 32'h10, 4'b0101, 32'h11223344, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDE22BE44, 1'b0);

    // be=0 write leaves memory untouched; low address bits are ignored
    applyStimulus(1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h13, 4'hF, 32'h0, 1'b0, 32'hDE22BE44, 1'b0);

    // Out-of-range accesses error out and never alias onto word 0
    applyStimulus(1, 1'b1, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b0);
    waitDrain(1);

    // Backpressure: fill the FIFO, hold the head, then release
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 32'(32'h20 + 4 * i), 4'hF, 32'(32'hA0A00000 + i), 1'b0, 32'h0, 1'b0);
    end
    waitDrain(1);
    bus1.rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b0, 32'(32'h20 + 4 * i), 4'hF, 32'h0, i[0], 32'(32'hA0A00000 + i), 1'b0);
    end
    driveA(1, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("full_gnt_low",  64'(bus1.gnt),    64'd0);
      checkOutput("held_rvalid",   64'(bus1.rvalid), 64'd1);
      checkOutput("held_rdata",    64'(bus1.rdata),  64'hA0A00000);
      checkOutput("held_rid",      64'(bus1.rid),    64'd0);
      checkOutput("full_count",    64'(dut1.count),  64'(MAXO));
    end
    @(posedge clk);
    #1 bus1.rready = 1'b1;
    @(negedge clk);
    checkOutput("gnt_retire_same_cycle", 64'(bus1.gnt), 64'd0);
    @(negedge clk);
    checkOutput("gnt_after_retire", 64'(bus1.gnt), 64'd1);
    @(posedge clk);
    pushExpected(1, 32'hA0A00004, 1'b0, 1'b0);
    #1;
    driveA(1, 1'b0, 1'b0, '0, '0, '0, '0);
    waitDrain(1);

    // Latency 3: rvalid three cycles after accept; accept+retire keeps count
    applyStimulus(2, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    waitDrain(2);
    for (int i = 0; i < 5; i++) begin
      driveA(2, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, i[0]);
      @(negedge clk);
      checkOutput("lat3_gnt",    64'(bus2.gnt),    64'd1);
      checkOutput($sformatf("lat3_rvalid_c%0d", i), 64'(bus2.rvalid), (i >= 3) ? 64'd1 : 64'd0);
      checkOutput($sformatf("lat3_count_c%0d", i),  64'(dut2.count),  (i < 3) ? 64'(i) : 64'd3);
      @(posedge clk);
      pushExpected(2, 32'hCAFEF00D, 1'b0, i[0]);
      #1;
    end
    driveA(2, 1'b0, 1'b0, '0, '0, '0, '0);
    waitDrain(2);

    // Reset with responses queued drops them but keeps memory
    bus1.rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b0, 32'(32'h20 + 4 * i), 4'hF, 32'h0, i[0], 32'(32'hA0A00000 + i), 1'b0);
    end
    @(negedge clk);
    checkOutput("pre_reset_rvalid", 64'(bus1.rvalid), 64'd1);
    checkOutput("pre_reset_count",  64'(dut1.count),  64'd3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus1.rready = 1'b1;
    @(negedge clk);
    checkOutput("reset_cycle_rvalid", 64'(bus1.rvalid), 64'd0);
    checkOutput("reset_cycle_gnt",    64'(bus1.gnt),    64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q1.delete();
    @(negedge clk);
    checkOutput("post_reset_rvalid", 64'(bus1.rvalid), 64'd0);
    checkOutput("post_reset_count",  64'(dut1.count),  64'd0);
    checkOutput("post_reset_gnt",    64'(bus1.gnt),    64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'hDE22BE44, 1'b0);
    applyStimulus(1, 1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 32'hA0A00001, 1'b0);
    waitDrain(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
